// File: rtl/wb_arbiter.sv
// Writeback arbiter: per-source FIFOs for ALU and LSU results feeding one registered RF write port.
// Define WB_ARB_STARVE_EN to compile in the ALU anti-starvation counter (default build: strict LSU priority).
module wb_arbiter #(
    parameter int XLEN       = 32,
    parameter int FIFO_DEPTH = 2,
    parameter int MAX_WAIT   = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            alu_valid,
    output logic            alu_ready,
    input  logic [4:0]      alu_rd,
    input  logic [XLEN-1:0] alu_data,
    input  logic            lsu_valid,
    output logic            lsu_ready,
    input  logic [4:0]      lsu_rd,
    input  logic [XLEN-1:0] lsu_data,
    output logic            rf_we,
    output logic [4:0]      rf_rd_addr,
    output logic [XLEN-1:0] rf_rd_data,
    output logic            pending
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || MAX_WAIT < 1) begin : gBadParams
        $error("wb_arbiter: FIFO_DEPTH must be a power of two >= 2 and MAX_WAIT >= 1");
    end

    logic [4:0]      aluRdMem_q   [FIFO_DEPTH];
    logic [XLEN-1:0] aluDataMem_q [FIFO_DEPTH];
    logic [4:0]      lsuRdMem_q   [FIFO_DEPTH];
    logic [XLEN-1:0] lsuDataMem_q [FIFO_DEPTH];
    logic [PW-1:0]   aluWptr_q, aluRptr_q, lsuWptr_q, lsuRptr_q;
    logic [CW-1:0]   aluCount_q, aluCount_d, lsuCount_q, lsuCount_d;
    logic            rfWe_q, rfWe_d;
    logic [4:0]      rfAddr_q, rfAddr_d;
    logic [XLEN-1:0] rfData_q, rfData_d;
    logic            aluPush, lsuPush, aluNonEmpty, lsuNonEmpty;
    logic            aluGrant, lsuGrant, aluForce;

    assign alu_ready   = !rst && (aluCount_q < DEPTH_C);
    assign lsu_ready   = !rst && (lsuCount_q < DEPTH_C);
    assign aluPush     = alu_valid && alu_ready;
    assign lsuPush     = lsu_valid && lsu_ready;
    assign aluNonEmpty = (aluCount_q != '0);
    assign lsuNonEmpty = (lsuCount_q != '0);
    assign pending     = aluNonEmpty || lsuNonEmpty;

    // LSU wins contested cycles unless the starvation override forces the ALU head through.
    assign lsuGrant = lsuNonEmpty && !(aluNonEmpty && aluForce);
    assign aluGrant = aluNonEmpty && !lsuGrant;

`ifdef WB_ARB_STARVE_EN
    localparam int SW = $clog2(MAX_WAIT + 1);
    localparam logic [SW-1:0] MAX_WAIT_C = SW'(MAX_WAIT);
    logic [SW-1:0] starve_q, starve_d;

    assign aluForce = (starve_q == MAX_WAIT_C);

    always_comb begin
        starve_d = starve_q;
        if (!aluNonEmpty || aluGrant) begin
            starve_d = '0;
        end else if (lsuGrant && !aluForce) begin
            starve_d = starve_q + SW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) starve_q <= '0;
        else     starve_q <= starve_d;
    end
`else
    assign aluForce = 1'b0;
`endif

    always_comb begin
        aluCount_d = aluCount_q + CW'(aluPush) - CW'(aluGrant);
        lsuCount_d = lsuCount_q + CW'(lsuPush) - CW'(lsuGrant);
        rfWe_d     = 1'b0;
        rfAddr_d   = rfAddr_q;
        rfData_d   = rfData_q;
        // Writes to x0 are consumed but never reach the port.
        if (lsuGrant) begin
            rfWe_d   = (lsuRdMem_q[lsuRptr_q] != 5'd0);
            rfAddr_d = lsuRdMem_q[lsuRptr_q];
            rfData_d = lsuDataMem_q[lsuRptr_q];
        end else if (aluGrant) begin
            rfWe_d   = (aluRdMem_q[aluRptr_q] != 5'd0);
            rfAddr_d = aluRdMem_q[aluRptr_q];
            rfData_d = aluDataMem_q[aluRptr_q];
        end
    end

    always_ff @(posedge clk) begin
        if (aluPush) begin
            aluRdMem_q[aluWptr_q]   <= alu_rd;
            aluDataMem_q[aluWptr_q] <= alu_data;
        end
        if (lsuPush) begin
            lsuRdMem_q[lsuWptr_q]   <= lsu_rd;
            lsuDataMem_q[lsuWptr_q] <= lsu_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            aluWptr_q  <= '0;
            aluRptr_q  <= '0;
            aluCount_q <= '0;
            lsuWptr_q  <= '0;
            lsuRptr_q  <= '0;
            lsuCount_q <= '0;
            rfWe_q     <= 1'b0;
            rfAddr_q   <= '0;
            rfData_q   <= '0;
        end else begin
            if (aluPush)  aluWptr_q <= aluWptr_q + PW'(1);
            if (aluGrant) aluRptr_q <= aluRptr_q + PW'(1);
            if (lsuPush)  lsuWptr_q <= lsuWptr_q + PW'(1);
            if (lsuGrant) lsuRptr_q <= lsuRptr_q + PW'(1);
            aluCount_q <= aluCount_d;
            lsuCount_q <= lsuCount_d;
            rfWe_q     <= rfWe_d;
            rfAddr_q   <= rfAddr_d;
            rfData_q   <= rfData_d;
        end
    end

    assign rf_we      = rfWe_q;
    assign rf_rd_addr = rfAddr_q;
    assign rf_rd_data = rfData_q;
endmodule

// File: tb/tb_wb_arbiter.sv
// Directed self-checking bench for wb_arbiter; inputs change and outputs are sampled on the falling edge.
// Starvation expectations follow WB_ARB_STARVE_EN when the bench is built with that macro.
module tb_wb_arbiter;
    logic        clk;
    logic        rst;
    logic        alu_valid, lsu_valid;
    logic        alu_ready, lsu_ready;
    logic [4:0]  alu_rd, lsu_rd;
    logic [31:0] alu_data, lsu_data;
    logic        rf_we;
    logic [4:0]  rf_rd_addr;
    logic [31:0] rf_rd_data;
    logic        pending;

    int checks = 0;
    int errors = 0;

    wb_arbiter #(.XLEN(32), .FIFO_DEPTH(2), .MAX_WAIT(4)) dut (
        .clk(clk), .rst(rst),
        .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd), .alu_data(alu_data),
        .lsu_valid(lsu_valid), .lsu_ready(lsu_ready), .lsu_rd(lsu_rd), .lsu_data(lsu_data),
        .rf_we(rf_we), .rf_rd_addr(rf_rd_addr), .rf_rd_data(rf_rd_data), .pending(pending)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    logic [4:0] expStream [7];
    logic [4:0] expRd;
    int         lsuNext;
    logic       accepted;

    initial begin
        rst = 1'b1; alu_valid = 1'b0; lsu_valid = 1'b0;
        alu_rd = '0; alu_data = '0; lsu_rd = '0; lsu_data = '0;
        step();
        step();
        checkOutput("rst_we", rf_we, 0);
        checkOutput("rst_addr", rf_rd_addr, 0);
        checkOutput("rst_data", rf_rd_data, 0);
        checkOutput("rst_pending", pending, 0);
        checkOutput("rst_alu_ready", alu_ready, 0);
        checkOutput("rst_lsu_ready", lsu_ready, 0);
        rst = 1'b0;
        #1;
        checkOutput("post_rst_alu_ready", alu_ready, 1);
        checkOutput("post_rst_lsu_ready", lsu_ready, 1);

        // Single ALU result: write appears two edges after the handshake, for one cycle.
        alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'hDEADBEEF;
        step();
        alu_valid = 1'b0;
        checkOutput("single_we_n1", rf_we, 0);
        checkOutput("single_pending", pending, 1);
        step();
        checkOutput("single_we_n2", rf_we, 1);
        checkOutput("single_addr", rf_rd_addr, 5);
        checkOutput("single_data", rf_rd_data, 32'hDEADBEEF);
        checkOutput("single_pending_done", pending, 0);
        step();
        checkOutput("single_we_n3", rf_we, 0);
        checkOutput("single_addr_hold", rf_rd_addr, 5);
        checkOutput("single_data_hold", rf_rd_data, 32'hDEADBEEF);

        // Contention: LSU written first, ALU the cycle after.
        alu_valid = 1'b1; alu_rd = 5'd1; alu_data = 32'h11;
        lsu_valid = 1'b1; lsu_rd = 5'd2; lsu_data = 32'h22;
        step();
        alu_valid = 1'b0; lsu_valid = 1'b0;
        checkOutput("cont_we0", rf_we, 0);
        step();
        checkOutput("cont_we1", rf_we, 1);
        checkOutput("cont_addr1", rf_rd_addr, 2);
        checkOutput("cont_data1", rf_rd_data, 32'h22);
        checkOutput("cont_pending1", pending, 1);
        step();
        checkOutput("cont_we2", rf_we, 1);
        checkOutput("cont_addr2", rf_rd_addr, 1);
        checkOutput("cont_data2", rf_rd_data, 32'h11);
        checkOutput("cont_pending2", pending, 0);
        step();
        checkOutput("cont_we3", rf_we, 0);

        // Back-to-back LSU stream: ready never drops, writes keep order.
        for (int i = 0; i < 3; i++) begin
            lsu_valid = 1'b1; lsu_rd = 5'(10 + i); lsu_data = 32'hA0 + 32'(i);
            checkOutput($sformatf("bp_ready%0d", i), lsu_ready, 1);
            step();
            if (i > 0) begin
                checkOutput($sformatf("bp_we%0d", i - 1), rf_we, 1);
                checkOutput($sformatf("bp_addr%0d", i - 1), rf_rd_addr, 32'(10 + i - 1));
            end
        end
        lsu_valid = 1'b0;
        step();
        checkOutput("bp_we2", rf_we, 1);
        checkOutput("bp_addr2", rf_rd_addr, 12);
        checkOutput("bp_data2", rf_rd_data, 32'hA2);
        checkOutput("bp_pending", pending, 0);
        step();
        checkOutput("bp_we_end", rf_we, 0);

        // x0 destination: consumed without a port write.
        alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 32'h1234;
        step();
        alu_valid = 1'b0;
        checkOutput("x0_pending_q", pending, 1);
        step();
        checkOutput("x0_we", rf_we, 0);
        checkOutput("x0_pending", pending, 0);
        step();
        checkOutput("x0_we_after", rf_we, 0);

        // Starvation: LSU kept busy while ALU rd=7 waits.
`ifdef WB_ARB_STARVE_EN
        expStream[0] = 5'd20; expStream[1] = 5'd21; expStream[2] = 5'd22; expStream[3] = 5'd23;
        expStream[4] = 5'd7;  expStream[5] = 5'd24; expStream[6] = 5'd25;
`else
        for (int i = 0; i < 7; i++) expStream[i] = 5'(20 + i);
`endif
        lsuNext = 20;
        alu_valid = 1'b1; alu_rd = 5'd7; alu_data = 32'h77;
        lsu_valid = 1'b1; lsu_rd = 5'(lsuNext); lsu_data = 32'h1000 + 32'(lsuNext);
        for (int i = 0; i < 8; i++) begin
            accepted = lsu_ready;
            step();
            alu_valid = 1'b0;
            if (accepted) begin
                lsuNext++;
                lsu_rd = 5'(lsuNext); lsu_data = 32'h1000 + 32'(lsuNext);
            end
            if (i > 0) begin
                expRd = expStream[i - 1];
                checkOutput($sformatf("starve_we%0d", i), rf_we, 1);
                checkOutput($sformatf("starve_addr%0d", i), rf_rd_addr, 32'(expRd));
                checkOutput($sformatf("starve_data%0d", i), rf_rd_data,
                            (expRd == 5'd7) ? 32'h77 : 32'h1000 + 32'(expRd));
            end
        end
        lsu_valid = 1'b0;
        step();
        checkOutput("drain_we0", rf_we, 1);
`ifdef WB_ARB_STARVE_EN
        checkOutput("drain_addr0", rf_rd_addr, 26);
        step();
        checkOutput("drain_we1", rf_we, 0);
`else
        checkOutput("drain_addr0", rf_rd_addr, 27);
        step();
        checkOutput("drain_we1", rf_we, 1);
        checkOutput("drain_addr1", rf_rd_addr, 7);
        checkOutput("drain_data1", rf_rd_data, 32'h77);
`endif
        checkOutput("drain_pending", pending, 0);
        step();

        // Reset with two entries queued discards them.
        alu_valid = 1'b1; alu_rd = 5'd3; alu_data = 32'h33;
        lsu_valid = 1'b1; lsu_rd = 5'd4; lsu_data = 32'h44;
        step();
        alu_valid = 1'b0; lsu_valid = 1'b0;
        rst = 1'b1;
        #1;
        checkOutput("mid_pending_pre", pending, 1);
        checkOutput("mid_alu_ready_rst", alu_ready, 0);
        checkOutput("mid_lsu_ready_rst", lsu_ready, 0);
        step();
        checkOutput("mid_we", rf_we, 0);
        checkOutput("mid_addr", rf_rd_addr, 0);
        checkOutput("mid_pending", pending, 0);
        rst = 1'b0;
        step();
        checkOutput("mid_we_after", rf_we, 0);
        checkOutput("mid_pending_after", pending, 0);
        checkOutput("mid_alu_ready_after", alu_ready, 1);
        checkOutput("mid_lsu_ready_after", lsu_ready, 1);
        step();
        checkOutput("mid_we_after2", rf_we, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/wb_arbiter.md
# wb_arbiter

Writeback arbiter that drives the register-file write port (`we`/`rd_addr`/`rd_data`) for the RV32 pipeline. It accepts completed results from two producers, the single-cycle ALU path and the variable-latency load/store unit, through valid/ready handshakes. Each producer has its own small FIFO. Each cycle the arbiter grants one result and presents it as a registered, single-cycle write.

## Interface
- `XLEN`, 32, data width of results and of the write port.
- `FIFO_DEPTH`, 2, entries per source FIFO; power of two, ≥2.
- `MAX_WAIT`, 4, consecutive lost arbitrations after which the ALU head wins; only used when the starvation feature is compiled in.

Ports:
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: synchronous reset, active-high.
- `alu_valid` in 1: ALU result valid.
- `alu_ready` out 1: ALU FIFO can accept.
- `alu_rd` in 5: ALU destination register.
- `alu_data` in XLEN: ALU result.
- `lsu_valid` in 1: LSU result valid.
- `lsu_ready` out 1: LSU FIFO can accept.
- `lsu_rd` in 5: LSU destination register.
- `lsu_data` in XLEN: LSU load data.
- `rf_we` out 1: register-file write enable.
- `rf_rd_addr` out 5: register-file write address.
- `rf_rd_data` out XLEN: register-file write data.
- `pending` out 1: at least one entry is queued in either FIFO.

## Operation
- Transfer into a FIFO when `x_valid && x_ready` at a rising edge. `x_ready = !rst && (count_x < FIFO_DEPTH)`; it does not depend on `x_valid`.
- There is no pass-through when full. A pop and a push in the same cycle on a full FIFO is not possible because ready is already low.
- Order is preserved within a source. No ordering exists between sources. Issue logic must never leave two in-flight writes to the same `rd` in different sources.
- Arbitration is over the FIFO heads each cycle:
  - Only one head is non-empty: that head is granted.
  - Both heads are non-empty: LSU wins, unless the starvation override is active (see Configuration).
- A granted entry is popped and loaded into the output register.
- An entry with `rd == 0` is still granted and popped, but the output register loads `rf_we = 0`. The write to x0 is dropped without a port write.
- With no grant, `rf_we` loads 0. `rf_rd_addr` and `rf_rd_data` hold their previous values.
- `pending = (count_alu != 0) || (count_lsu != 0)`, combinational.
- FIFO pointers wrap modulo `FIFO_DEPTH`. The count is `$clog2(FIFO_DEPTH)+1` bits and never wraps.

## Timing
- Reset values:
  - `rf_we = 0`, `rf_rd_addr = 0`, `rf_rd_data = 0`.
  - Both counts and pointers = 0, starvation counter = 0, `pending = 0`.
  - `alu_ready` and `lsu_ready` = 0 while `rst` is high, and 1 in the first cycle after `rst` falls.
- Reset mid-operation discards all queued entries. No write occurs in the cycle after reset.
- Latency: a result accepted at edge N is granted in cycle N+1 if it is uncontested. `rf_we` is then high during cycle N+2, i.e. 2 cycles from handshake to write.
- Throughput is one write per cycle, sustained.
- `rf_we` is high for exactly one cycle per granted non-x0 entry.
- Simultaneous accepts on both sources in one cycle are legal.

## Configuration
- `WB_ARB_STARVE_EN`: compiles in the starvation counter.
- Counter behaviour:
  - Increments each cycle the ALU head is non-empty and loses to LSU.
  - Resets to 0 when ALU is granted, or when the ALU FIFO is empty.
  - Saturates at `MAX_WAIT`.
- When the counter equals `MAX_WAIT`, ALU wins the next contested cycle.
- Without the macro: strict LSU priority. ALU can be blocked for as long as LSU keeps its FIFO non-empty.

## Test plan
- Single ALU result: after reset, `alu_rd=5`, `alu_data=0xDEADBEEF` accepted at edge N → `rf_we=1`, `rf_rd_addr=5`, `rf_rd_data=0xDEADBEEF` during cycle N+2 only.
- Contention: both sources valid in the same cycle (ALU rd=1/0x11, LSU rd=2/0x22) → write rd=2 first, then rd=1 in the following cycle.
- Backpressure: hold `lsu_valid` for 3 cycles while ALU is idle. Expected: `lsu_ready` stays 1 because one pop per cycle keeps count<2, and three consecutive writes occur in order.
- x0 drop: ALU `rd=0`, data 0x1234 → entry popped, `pending` falls, `rf_we` stays 0.
- Starvation with `WB_ARB_STARVE_EN`, `MAX_WAIT=4`: LSU continuously valid, ALU entry rd=7 queued. Expected: four LSU writes, then rd=7, then LSU resumes. Without the macro, rd=7 waits until LSU goes idle.
- Reset mid-stream: assert `rst` with 2 entries queued → next cycles `rf_we=0`, `pending=0`, readies low during reset.
